// File: rtl/pipe_mux_nto1.sv
// N-to-1 WIDTH-bit selector with one registered output stage, valid/ready flow control and
// invalid-select error reporting. Define PIPE_MUX_ERRCNT_EN to add the saturating err_count.
module pipe_mux_nto1 #(
    parameter  int WIDTH  = 16,
    parameter  int NUM_IN = 3,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    err_sel,
    output logic                    err_sticky,
    input  logic                    err_clr,
    output logic [7:0]              err_count
);

    localparam logic [SEL_W:0] NUM_IN_L = (SEL_W+1)'(NUM_IN);

    logic [NUM_IN-1:0][WIDTH-1:0] lane;
    logic [WIDTH-1:0]             sel_data;
    logic                         sel_ok;
    logic                         accept;
    logic                         pop;
    logic                         bad_acc;

    // AND-OR selection: unselected slices are forced to zero, so X on them never reaches out_data.
    for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
        assign lane[i] = (sel == SEL_W'(i)) ? in_data[i*WIDTH +: WIDTH] : '0;
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_IN; i++) sel_data = sel_data | lane[i];
    end

    assign sel_ok   = ({1'b0, sel} < NUM_IN_L);
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign bad_acc  = accept && !sel_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            err_sel    <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            err_sel <= bad_acc;
            if (accept) begin
                // An invalid select is consumed: it empties the stage but leaves the data register alone.
                out_valid <= sel_ok;
                if (sel_ok) out_data <= sel_data;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
            if (bad_acc)      err_sticky <= 1'b1;
            else if (err_clr) err_sticky <= 1'b0;
        end
    end

`ifdef PIPE_MUX_ERRCNT_EN
    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)                       cnt <= '0;
        else if (err_clr)                 cnt <= bad_acc ? 8'd1 : 8'd0;
        else if (bad_acc && cnt != 8'hFF) cnt <= cnt + 8'd1;
    end

    assign err_count = cnt;
`else
    assign err_count = '0;
`endif

endmodule
